// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one request at a time, a fixed
// number of wait states, then a word load or a byte-enabled store.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the response is a one-cycle resp_valid strobe with no back-pressure.

  localparam int         DEPTH     = 1 << (ADDR_W - 2);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_n;
  logic [3:0]        wait_cnt;
  logic              lat_we;
  logic [31:0]       lat_addr, lat_wdata;
  logic [3:0]        lat_be;
  logic              accept, acc_en, acc_we, acc_err;
  logic [31:0]       acc_addr, acc_wdata;
  logic [3:0]        acc_be;
  logic [ADDR_W-3:0] acc_idx;
  logic [31:0]       mem [DEPTH];

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign accept     = req_valid && req_ready;

  // With no wait states the access uses the live request on the accept edge;
  // otherwise it uses the latched request on the last wait edge.
  always_comb begin
    if (ZERO_WAIT) begin
      acc_en    = accept && !rst;
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_en    = (state == S_WAIT) && (wait_cnt == 4'd1) && !rst;
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
    end
    acc_idx = acc_addr[ADDR_W-1:2];
    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:ADDR_W] != '0);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (req_valid) state_n = ZERO_WAIT ? S_RESP : S_WAIT;
      S_WAIT: if (wait_cnt == 4'd1) state_n = S_RESP;
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_be     <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        wait_cnt  <= WAIT_INIT;
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (acc_en) begin
        resp_err   <= acc_err;
        resp_rdata <= (!acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
      end
    end
  end

  // Storage has no reset; acc_en is already gated off while rst is high.
  always_ff @(posedge clk) begin
    if (acc_en && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 0 and 15 wait states) checked
// against a byte-level memory model with known-byte tracking.
module tb_dmem_responder;

  localparam int WS [3] = '{2, 0, 15};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vld = 3'b000;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  be = 4'd0;
  logic        rdy [3], rv [3], er [3], bz [3];
  logic [31:0] rd [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mm [3][256];
  logic [3:0]  kb [3][256];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_be(be), .resp_valid(rv[0]),
    .resp_rdata(rd[0]), .resp_err(er[0]), .busy(bz[0]));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_be(be), .resp_valid(rv[1]),
    .resp_rdata(rd[1]), .resp_err(er[1]), .busy(bz[1]));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_be(be), .resp_valid(rv[2]),
    .resp_rdata(rd[2]), .resp_err(er[2]), .busy(bz[2]));

  // Reference: 1 KiB byte-addressed space of 32-bit words, updates only when legal.
  function automatic void model(input int d, input logic w, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] b,
                                output logic [31:0] ex_rd, output logic ex_err,
                                output bit ex_known);
    int wi;
    ex_err   = (a % 4 != 0) || (a >= 32'd1024);
    ex_rd    = 32'd0;
    ex_known = 1'b1;
    if (!ex_err) begin
      wi = int'(a / 4);
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (b[i]) begin
            mm[d][wi][8*i +: 8] = wd[8*i +: 8];
            kb[d][wi][i] = 1'b1;
          end
        end
      end else begin
        ex_rd    = mm[d][wi];
        ex_known = (kb[d][wi] == 4'hF);
      end
    end
  endfunction

  task automatic run_req(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b,
                         output logic [31:0] o_rd, output logic o_err,
                         output int lat, output int nresp, output int nbusy,
                         output int rdy_in_resp);
    int t;
    t = 0;
    @(negedge clk);
    while (!rdy[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    we = w; addr = a; wdata = wd; be = b; vld[d] = 1'b1;
    @(posedge clk);
    #1 vld[d] = 1'b0;
    lat = -1; nresp = 0; nbusy = 0; rdy_in_resp = 0; o_rd = 32'd0; o_err = 1'b0;
    for (int k = 1; k <= WS[d] + 6; k++) begin
      @(negedge clk);
      if (bz[d]) nbusy++;
      if (rv[d]) begin
        nresp++;
        if (rdy[d]) rdy_in_resp++;
        if (lat < 0) begin
          lat = k; o_rd = rd[d]; o_err = er[d];
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] o_rd, ex_rd;
    logic o_err, ex_err;
    bit kn;
    int lat, nr, nb, rr;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if ({rdy[d], rv[d], bz[d], er[d], rd[d]} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0}) begin
          n_fail++;
          $display("FAIL rst_state dut%0d got rdy=%b rv=%b busy=%b err=%b rdata=%h exp 1 0 0 0 0",
                   d, rdy[d], rv[d], bz[d], er[d], rd[d]);
        end
      end
    end
    rst = 1'b0;
    model(0, 1'b1, 32'h10, 32'h11112222, 4'hF, ex_rd, ex_err, kn);
    run_req(0, 1'b1, 32'h10, 32'h11112222, 4'hF, o_rd, o_err, lat, nr, nb, rr);
    // Store of DEADBEEF is accepted then killed by reset during its wait states.
    @(negedge clk);
    we = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF; be = 4'hF; vld[0] = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (rdy[0] !== 1'b1 || rv[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid cyc%0d got rdy=%b rv=%b exp rdy=1 rv=0", c, rdy[0], rv[0]);
      end
    end
    rst = 1'b0; vld[0] = 1'b0;
    model(0, 1'b0, 32'h10, 32'h0, 4'h0, ex_rd, ex_err, kn);
    run_req(0, 1'b0, 32'h10, 32'h0, 4'h0, o_rd, o_err, lat, nr, nb, rr);
    n_checks++;
    if (o_rd !== 32'h11112222 || o_rd !== ex_rd || o_err !== 1'b0 || nr !== 1) begin
      n_fail++;
      $display("FAIL rst_drop got rdata=%h err=%b nresp=%0d exp rdata=11112222 err=0 nresp=1",
               o_rd, o_err, nr);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] o_rd, ex_rd;
    logic o_err, ex_err;
    bit kn;
    int lat, nr, nb, rr;
    model(0, 1'b1, 32'h20, 32'h12345678, 4'hF, ex_rd, ex_err, kn);
    run_req(0, 1'b1, 32'h20, 32'h12345678, 4'hF, o_rd, o_err, lat, nr, nb, rr);
    n_checks++;
    if (lat !== 3 || nr !== 1 || o_err !== 1'b0 || o_rd !== 32'd0) begin
      n_fail++;
      $display("FAIL sl_store got lat=%0d nresp=%0d err=%b rdata=%h exp 3 1 0 0", lat, nr, o_err, o_rd);
    end
    model(0, 1'b0, 32'h20, 32'h0, 4'h0, ex_rd, ex_err, kn);
    run_req(0, 1'b0, 32'h20, 32'h0, 4'h0, o_rd, o_err, lat, nr, nb, rr);
    n_checks++;
    if (lat !== 3 || nr !== 1 || o_err !== 1'b0 || o_rd !== ex_rd || rr !== 0) begin
      n_fail++;
      $display("FAIL sl_load got lat=%0d nresp=%0d err=%b rdata=%h rdy_in_resp=%0d exp 3 1 0 %h 0",
               lat, nr, o_err, o_rd, rr, ex_rd);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] o_rd, ex_rd;
    logic o_err, ex_err;
    bit kn;
    int lat, nr, nb, rr;
    model(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, ex_rd, ex_err, kn);
    run_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, o_rd, o_err, lat, nr, nb, rr);
    model(0, 1'b0, 32'h20, 32'h0, 4'h0, ex_rd, ex_err, kn);
    run_req(0, 1'b0, 32'h20, 32'h0, 4'h0, o_rd, o_err, lat, nr, nb, rr);
    n_checks++;
    if (o_rd !== 32'h12BB56DD || o_rd !== ex_rd || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL be_0101 got rdata=%h err=%b exp rdata=12BB56DD err=0", o_rd, o_err);
    end
    model(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, ex_rd, ex_err, kn);
    run_req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, o_rd, o_err, lat, nr, nb, rr);
    n_checks++;
    if (o_err !== 1'b0 || nr !== 1 || lat !== 3) begin
      n_fail++;
      $display("FAIL be_0000_resp got err=%b nresp=%0d lat=%0d exp 0 1 3", o_err, nr, lat);
    end
    model(0, 1'b0, 32'h20, 32'h0, 4'h0, ex_rd, ex_err, kn);
    run_req(0, 1'b0, 32'h20, 32'h0, 4'h0, o_rd, o_err, lat, nr, nb, rr);
    n_checks++;
    if (o_rd !== ex_rd) begin
      n_fail++;
      $display("FAIL be_0000_load got rdata=%h exp %h", o_rd, ex_rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] o_rd, ex_rd;
    logic o_err, ex_err;
    bit kn;
    int lat, nr, nb, rr;
    model(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, ex_rd, ex_err, kn);
    run_req(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, o_rd, o_err, lat, nr, nb, rr);
    run_req(0, 1'b0, 32'h22, 32'h0, 4'h0, o_rd, o_err, lat, nr, nb, rr);
    n_checks++;
    if (o_err !== 1'b1 || o_rd !== 32'd0 || lat !== 3) begin
      n_fail++;
      $display("FAIL err_misalign got err=%b rdata=%h lat=%0d exp 1 0 3", o_err, o_rd, lat);
    end
    run_req(0, 1'b1, 32'h400, 32'h55555555, 4'hF, o_rd, o_err, lat, nr, nb, rr);
    n_checks++;
    if (o_err !== 1'b1 || o_rd !== 32'd0) begin
      n_fail++;
      $display("FAIL err_range got err=%b rdata=%h exp 1 0", o_err, o_rd);
    end
    model(0, 1'b0, 32'h0, 32'h0, 4'h0, ex_rd, ex_err, kn);
    run_req(0, 1'b0, 32'h0, 32'h0, 4'h0, o_rd, o_err, lat, nr, nb, rr);
    n_checks++;
    if (o_rd !== 32'hCAFEF00D || o_rd !== ex_rd || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_nowrite got rdata=%h err=%b exp CAFEF00D 0", o_rd, o_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] o_rd, ex_rd, d32;
    logic [31:0] exp_q [$];
    int acc_cyc [$];
    int resp_cyc [$];
    logic o_err, ex_err, acc_now;
    bit kn;
    int lat, nr, nb, rr, idx;
    for (int i = 0; i < 4; i++) begin
      d32 = $urandom;
      model(1, 1'b1, 32'h40 + 4*i, d32, 4'hF, ex_rd, ex_err, kn);
      run_req(1, 1'b1, 32'h40 + 4*i, d32, 4'hF, o_rd, o_err, lat, nr, nb, rr);
      n_checks++;
      if (lat !== 1) begin
        n_fail++;
        $display("FAIL b2b_store_lat got %0d exp 1", lat);
      end
    end
    for (int i = 0; i < 4; i++) begin
      model(1, 1'b0, 32'h40 + 4*i, 32'h0, 4'h0, ex_rd, ex_err, kn);
      exp_q.push_back(ex_rd);
    end
    @(negedge clk);
    idx = 0; we = 1'b0; addr = 32'h40; vld[1] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      acc_now = rdy[1] && vld[1];
      if (rv[1]) begin
        resp_cyc.push_back(c);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_resp cyc%0d got rdata=%h exp no response", c, rd[1]);
        end else begin
          ex_rd = exp_q.pop_front();
          if (rd[1] !== ex_rd || rdy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_resp cyc%0d got rdata=%h rdy=%b exp %h 0", c, rd[1], rdy[1], ex_rd);
          end
        end
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        acc_cyc.push_back(c);
        idx++;
        if (idx < 4) addr = 32'h40 + 4*idx;
        else vld[1] = 1'b0;
      end
      @(negedge clk);
    end
    vld[1] = 1'b0;
    n_checks++;
    if (acc_cyc.size() !== 4 || resp_cyc.size() !== 4) begin
      n_fail++;
      $display("FAIL b2b_count got accepts=%0d resps=%0d exp 4 4", acc_cyc.size(), resp_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (resp_cyc[i] !== acc_cyc[i] + 1 || (i > 0 && acc_cyc[i] !== acc_cyc[i-1] + 2)) begin
          n_fail++;
          $display("FAIL b2b_timing req%0d got acc=%0d resp=%0d exp spacing 2, resp acc+1",
                   i, acc_cyc[i], resp_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_max_wait();
    logic [31:0] o_rd, ex_rd;
    logic o_err, ex_err;
    bit kn;
    int lat, nr, nb, rr;
    model(2, 1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, ex_rd, ex_err, kn);
    run_req(2, 1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, o_rd, o_err, lat, nr, nb, rr);
    model(2, 1'b0, 32'h3FC, 32'h0, 4'h0, ex_rd, ex_err, kn);
    run_req(2, 1'b0, 32'h3FC, 32'h0, 4'h0, o_rd, o_err, lat, nr, nb, rr);
    n_checks++;
    if (nb !== 16 || nr !== 1 || lat !== 16 || o_rd !== ex_rd || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL max_wait got busy=%0d nresp=%0d lat=%0d rdata=%h err=%b exp 16 1 16 %h 0",
               nb, nr, lat, o_rd, o_err, ex_rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] o_rd, ex_rd, a, wd;
    logic o_err, ex_err, w;
    logic [3:0] b;
    bit kn;
    int lat, nr, nb, rr, d, sel;
    for (int n = 0; n < 40; n++) begin
      d   = (n % 2 == 0) ? 0 : 1;
      sel = $urandom_range(0, 7);
      a   = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      else if (sel == 1) a = a | (32'($urandom_range(1, 255)) << 10);
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      b  = 4'($urandom_range(0, 15));
      model(d, w, a, wd, b, ex_rd, ex_err, kn);
      run_req(d, w, a, wd, b, o_rd, o_err, lat, nr, nb, rr);
      n_checks++;
      if (lat !== WS[d] + 1 || nr !== 1 || o_err !== ex_err || (kn && o_rd !== ex_rd)) begin
        n_fail++;
        $display("FAIL rand%0d dut%0d we=%b addr=%h got lat=%0d nresp=%0d err=%b rdata=%h exp %0d 1 %b %h",
                 n, d, w, a, lat, nr, o_err, o_rd, WS[d] + 1, ex_err, ex_rd);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 256; i++) kb[d][i] = 4'h0;
    test_reset();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_back_to_back();
    test_max_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS32 core's load/store port, i.e. the memory-side end of the CPU data interface. It accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, and then performs a word read or a byte-enabled write on internal word storage. It returns exactly one single-cycle response per accepted request, with read data and an error flag. It replaces the zero-latency behavioural array, so the core's stall logic can be exercised against a realistic slave.

## Interface
Parameters:
- ADDR_W, 10, byte-address bits decoded; storage is 2^(ADDR_W-2) 32-bit words.
- WAIT_CYCLES, 2, wait states inserted before the access; legal range 0..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i selects wdata[8i+7:8i].
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request rejected (misaligned or out of range); qualified by resp_valid.
- busy  out  1  a request has been accepted and its response has not yet been issued.

## Operation
- FSM states:
  - IDLE: req_ready = 1.
  - WAIT: counts wait states.
  - RESP: resp_valid = 1.
- Accept: on an edge where req_valid && req_ready, latch we, addr, wdata and be, and load wait_cnt with WAIT_CYCLES.
  - If WAIT_CYCLES = 0, go directly to RESP.
  - Otherwise go to WAIT.
- WAIT: wait_cnt decrements once per cycle. On the edge where wait_cnt = 1, perform the access and go to RESP. With WAIT_CYCLES = 0 the access is performed on the accept edge itself.
- Access rules:
  - Word index = addr[ADDR_W-1:2].
  - Error if addr[1:0] != 0 or addr[31:ADDR_W] != 0. On error: no storage change, resp_rdata = 0, resp_err = 1.
  - Load: resp_rdata = the stored word. req_be is ignored.
  - Store: only the bytes with be[i] = 1 are updated; resp_rdata = 0. A store with be = 4'b0000 is legal, changes nothing, and gives resp_err = 0.
- RESP lasts exactly one cycle, then returns to IDLE. There is no response back-pressure.
- req_ready = (state == IDLE). Inputs are ignored while req_ready = 0.
- busy = (state != IDLE).
- Storage is not reset; its contents are undefined until written.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, busy 0, wait_cnt 0.
- Accept on edge N: resp_valid is high in the cycle following edge N+WAIT_CYCLES and low otherwise. Latency is therefore WAIT_CYCLES+1 cycles from the accept edge to the response cycle.
- Throughput: one request per WAIT_CYCLES+2 cycles. req_ready rises in the cycle after the resp_valid cycle.
- resp_rdata and resp_err are registered. They hold their values until the next response and are meaningful only while resp_valid = 1.
- Read-after-write: a load accepted after a store's response observes the stored data.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately.
  - A pending store whose access edge has not yet occurred is never performed.
  - No response is issued for the dropped request.
- req_valid held high across the RESP cycle is not accepted until the following IDLE cycle.

## Test plan
- Reset behaviour: assert rst for 3 cycles, with req_valid = 1, during a WAIT-state store of 0xDEADBEEF to 0x10; release and load 0x10 -> old contents unchanged; check req_ready = 1 and resp_valid = 0 throughout reset.
- Store/load, WAIT_CYCLES = 2: store 0x12345678 to 0x20 with be = 1111, then load 0x20 -> resp_valid exactly 3 cycles after each accept edge, resp_rdata = 0x12345678, resp_err = 0.
- Byte enables: over 0x12345678 at 0x20, store 0xAABBCCDD with be = 0101 -> load returns 0x12BB56DD; a store with be = 0000 leaves 0x12BB56DD.
- Errors: load 0x22 -> resp_err = 1, resp_rdata = 0; store to 0x400 (ADDR_W = 10) -> resp_err = 1, and a load of 0x000 is unchanged.
- Zero wait (WAIT_CYCLES = 0), back-to-back: hold req_valid high with 4 loads -> one accept every 2 cycles; each response arrives the cycle after its accept; req_ready is low during each response cycle.
- Max wait (WAIT_CYCLES = 15): single load -> busy high for 16 cycles, resp_valid high for exactly 1 cycle, 16 cycles after the accept edge.
